// File: rtl/fp_add_operand_stage_if.sv
// Operand-stage bus: IEEE pair in from issue, classified pair out to the adder.
// master = issuing/consuming side, slave = the operand stage itself.
interface fp_add_operand_stage_if #(
  parameter int SIZE_IEEE      = 32,
  parameter int SIZE           = 34,
  parameter int SIZE_FLUSH_CNT = 16
);
  logic                      in_valid;
  logic                      in_ready;
  logic [SIZE_IEEE-1:0]      in_a;
  logic [SIZE_IEEE-1:0]      in_b;
  logic                      in_sub;
  logic [1:0]                in_conversion;
  logic                      out_valid;
  logic                      out_ready;
  logic [SIZE-1:0]           a_number_o;
  logic [SIZE-1:0]           b_number_o;
  logic                      sub_o;
  logic [1:0]                conversion_o;
  logic [SIZE_FLUSH_CNT-1:0] flush_cnt_o;

  modport master (
    output in_valid, in_a, in_b, in_sub, in_conversion, out_ready,
    input  in_ready, out_valid, a_number_o, b_number_o, sub_o, conversion_o, flush_cnt_o
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, in_conversion, out_ready,
    output in_ready, out_valid, a_number_o, b_number_o, sub_o, conversion_o, flush_cnt_o
  );
endinterface

// File: rtl/fp_add_operand_stage.sv
// Classifies IEEE operand pairs into {exc, s, e, f}, flushing denormals; 1-cycle latency.
// Two-entry skid buffer (M drives outputs, S catches a stalled accept); in_ready is registered.
module fp_add_operand_stage #(
  parameter int size_mantissa        = 24,
  parameter int size_exponent        = 8,
  parameter int size_exception_field = 2,
  parameter int size_flush_cnt       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fp_add_operand_stage_if.slave bus
);
  localparam int size_ieee = size_exponent + size_mantissa;
  localparam int size      = size_mantissa + size_exponent + size_exception_field;
  localparam int size_frac = size_mantissa - 1;

  localparam logic [size_exception_field-1:0] zero          = 0;
  localparam logic [size_exception_field-1:0] normal_number = 1;
  localparam logic [size_exception_field-1:0] infinity      = 2;
  localparam logic [size_exception_field-1:0] NaN           = 3;

  typedef struct packed {
    logic [size-1:0] a;
    logic [size-1:0] b;
    logic            sub;
    logic [1:0]      conv;
  } pair_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  function automatic logic [size-1:0] classify(input logic [size_ieee-1:0] w);
    logic [size_exponent-1:0] e;
    logic [size_frac-1:0]     f;
    e = w[size_ieee-2 -: size_exponent];
    f = w[size_frac-1:0];
    if (e == '0)
      classify = '0;
    else if (&e)
      classify = {(f == '0) ? infinity : NaN, w};
    else
      classify = {normal_number, w};
  endfunction

  function automatic logic is_denormal(input logic [size_ieee-1:0] w);
    is_denormal = (w[size_ieee-2 -: size_exponent] == '0) && (w[size_frac-1:0] != '0);
  endfunction

  state_t                    state_q;
  pair_t                     m_q, s_q;
  pair_t                     in_pair;
  logic                      out_valid_q, in_ready_q;
  logic [size_flush_cnt-1:0] flush_cnt_q, flush_cnt_d;
  logic [1:0]                n_flush;
  logic [size_flush_cnt:0]   flush_sum;
  logic                      accept;

  assign in_pair = {classify(bus.in_a), classify(bus.in_b), bus.in_sub, bus.in_conversion};
  assign accept  = bus.in_valid && in_ready_q;

  // Counter saturates: the carry out of the widened sum pins it at all-ones.
  assign n_flush     = {1'b0, is_denormal(bus.in_a)} + {1'b0, is_denormal(bus.in_b)};
  assign flush_sum   = {1'b0, flush_cnt_q} + {{(size_flush_cnt-1){1'b0}}, n_flush};
  assign flush_cnt_d = flush_sum[size_flush_cnt] ? '1 : flush_sum[size_flush_cnt-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      m_q         <= '0;
      s_q         <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      flush_cnt_q <= '0;
    end else begin
      if (accept)
        flush_cnt_q <= flush_cnt_d;
      case (state_q)
        EMPTY: begin
          if (accept) begin
            m_q         <= in_pair;
            out_valid_q <= 1'b1;
            state_q     <= ONE;
          end
        end
        ONE: begin
          if (accept && bus.out_ready) begin
            m_q <= in_pair;
          end else if (accept) begin
            s_q        <= in_pair;
            in_ready_q <= 1'b0;
            state_q    <= FULL;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so the only event is M draining.
          if (bus.out_ready) begin
            m_q        <= s_q;
            in_ready_q <= 1'b1;
            state_q    <= ONE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= EMPTY;
        end
      endcase
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.a_number_o   = m_q.a;
  assign bus.b_number_o   = m_q.b;
  assign bus.sub_o        = m_q.sub;
  assign bus.conversion_o = m_q.conv;
  assign bus.flush_cnt_o  = flush_cnt_q;
endmodule

// File: tb/tb_fp_add_operand_stage.sv
// Scoreboard bench for fp_add_operand_stage: directed cases plus a random stall phase.
// Accepted pairs are modelled at the negedge before the accepting edge and popped on drain.
module tb_fp_add_operand_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  fp_add_operand_stage_if bus ();

  fp_add_operand_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_pop   = 0;
  logic [70:0] sbq[$];
  logic [15:0] exp_flush = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [33:0] model(input logic [31:0] w);
    logic [7:0]  e;
    logic [22:0] f;
    e = w[30:23];
    f = w[22:0];
    if (e == 8'h00) return 34'h0;
    if (e == 8'hFF) return {(f == 23'h0) ? 2'd2 : 2'd3, w};
    return {2'd1, w};
  endfunction

  function automatic logic [1:0] dn(input logic [31:0] w);
    return (w[30:23] == 8'h00 && w[22:0] != 23'h0) ? 2'd1 : 2'd0;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 4))
      0: w[30:0] = '0;
      1: begin w[30:23] = 8'h00; w[22:0] = 23'($urandom_range(1, 8388607)); end
      2: begin w[30:23] = 8'hFF; w[22:0] = '0; end
      3: begin w[30:23] = 8'hFF; w[22:0] = 23'($urandom_range(1, 8388607)); end
      default: w[30:23] = 8'($urandom_range(1, 254));
    endcase
    return w;
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [70:0] e;
    logic [16:0] s;
    if (rst_n) begin
      check("flush_cnt", bus.flush_cnt_o, exp_flush);
      if (bus.in_valid && bus.in_ready) begin
        sbq.push_back({model(bus.in_a), model(bus.in_b), bus.in_sub, bus.in_conversion});
        s = {1'b0, exp_flush} + {15'd0, dn(bus.in_a)} + {15'd0, dn(bus.in_b)};
        exp_flush = (s > 17'hFFFF) ? 16'hFFFF : s[15:0];
      end
      if (bus.out_valid && bus.out_ready) begin
        check("sb_nonempty", sbq.size() > 0, 1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          check("sb_a", bus.a_number_o, e[70:37]);
          check("sb_b", bus.b_number_o, e[36:3]);
          check("sb_ctl", {bus.sub_o, bus.conversion_o}, e[2:0]);
        end
        n_pop++;
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s, input logic [1:0] c);
    bit ok;
    ok = 0;
    bus.in_valid = 1'b1;
    bus.in_a = a; bus.in_b = b; bus.in_sub = s; bus.in_conversion = c;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    check("send_accepted", ok, 1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && sbq.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("drained", sbq.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  p;
    bit  done;
    bus.in_valid = 0; bus.in_a = 0; bus.in_b = 0; bus.in_sub = 0;
    bus.in_conversion = 0; bus.out_ready = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_a", bus.a_number_o, 0);
    check("rst_b", bus.b_number_o, 0);
    check("rst_flush", bus.flush_cnt_o, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // T1 normals, 1-cycle latency
    bus.out_ready = 1'b1;
    send(32'h3F800000, 32'h40000000, 1'b0, 2'd0);
    check("t1_valid", bus.out_valid, 1);
    check("t1_a", bus.a_number_o, 34'h13F800000);
    check("t1_b", bus.b_number_o, 34'h140000000);
    check("t1_sub", bus.sub_o, 0);

    // T2 denormal flush and -0
    send(32'h00000001, 32'h80000000, 1'b1, 2'd2);
    check("t2_a", bus.a_number_o, 0);
    check("t2_b", bus.b_number_o, 0);
    check("t2_flush", bus.flush_cnt_o, 16'd1);
    check("t2_ctl", {bus.sub_o, bus.conversion_o}, 3'b110);

    // T3 infinity and NaN
    send(32'h7F800000, 32'hFFC00000, 1'b0, 2'd1);
    check("t3_a", bus.a_number_o, 34'h27F800000);
    check("t3_b", bus.b_number_o, 34'h3FFC00000);

    // T4 stall: P0 in M, P1 in S, P2 held off
    wait_drain();
    bus.out_ready = 1'b0;
    send(32'h3F800000, 32'h3F800000, 1'b0, 2'd0);
    send(32'h40400000, 32'h7F800000, 1'b1, 2'd1);
    bus.in_valid = 1'b1; bus.in_a = 32'hC0800000; bus.in_b = 32'h00400000;
    bus.in_sub = 1'b0; bus.in_conversion = 2'd3;
    repeat (3) begin @(posedge clk); #1; end
    check("t4_in_ready", bus.in_ready, 0);
    check("t4_out_valid", bus.out_valid, 1);
    check("t4_m_is_p0", bus.b_number_o, 34'h13F800000);
    p = n_pop;
    bus.out_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("t4_three_pops", n_pop - p, 3);
    check("t4_empty_after", bus.out_valid, 0);

    // Random traffic with random backpressure
    done = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
          send(rand_op(), rand_op(), 1'($urandom), 2'($urandom));
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          bus.out_ready = 1'($urandom);
        end
      end
    join
    bus.out_ready = 1'b1;
    wait_drain();

    // T6 async reset while FULL
    bus.out_ready = 1'b0;
    send(32'h3F800000, 32'h40000000, 1'b0, 2'd0);
    send(32'h00000005, 32'h00000007, 1'b0, 2'd0);
    check("t6_full", bus.in_ready, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_out_valid", bus.out_valid, 0);
    check("t6_in_ready", bus.in_ready, 1);
    check("t6_a", bus.a_number_o, 0);
    check("t6_flush", bus.flush_cnt_o, 0);
    sbq.delete();
    exp_flush = '0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(32'hBF800000, 32'h7F800001, 1'b1, 2'd2);
    check("t6_relat_valid", bus.out_valid, 1);
    check("t6_relat_a", bus.a_number_o, 34'h1BF800000);
    check("t6_relat_b", bus.b_number_o, 34'h37F800001);

    // T5 flush-counter saturation
    for (int i = 0; i < 32767; i++)
      send(32'h00000001, 32'h80000001, 1'b0, 2'd0);
    check("t5_fffe", bus.flush_cnt_o, 16'hFFFE);
    send(32'h00000003, 32'h007FFFFF, 1'b0, 2'd0);
    check("t5_sat", bus.flush_cnt_o, 16'hFFFF);
    send(32'h80000002, 32'h00000004, 1'b0, 2'd0);
    check("t5_hold", bus.flush_cnt_o, 16'hFFFF);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
